adc_tape_slicer: RTL and testbench

Parametrised cassette-audio bit slicer for the ADC tape input path. It sits between the `ltc2308` sample stream and the core's `casdout` input, replacing the fixed 512-tap shift-register averager. It removes DC with a running average over a circular RAM window, then slices the signal with saturating hysteresis thresholds. It also adds edge timing, carrier detect, a warm-up gate and an overrun flag.

---
 rtl/adc_tape_slicer.sv | 216 +++++++++++++++++++++
 tb/tb_adc_tape_slicer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_tape_slicer.sv
// adc_tape_slicer: DC-removing hysteresis slicer for the cassette ADC path.
// Running average over a circular RAM window, edge timing, carrier detect.
module adc_tape_slicer #(
    parameter int SAMPLE_W    = 12,
    parameter int AVG_LOG2    = 9,
    parameter int HYST        = 100,
    parameter int INVERT      = 1,
    parameter int CARRIER_MAX = 4800
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_sync,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                bit_out,
    output logic                bit_edge,
    output logic [15:0]         period,
    output logic                period_valid,
    output logic                carrier,
    output logic [SAMPLE_W-1:0] avg_out,
    output logic                warm,
    output logic                overrun
);

    localparam int TW    = SAMPLE_W + AVG_LOG2;
    localparam int DEPTH = 1 << AVG_LOG2;

    localparam logic [AVG_LOG2:0]   FILL_FULL = (AVG_LOG2+1)'(DEPTH);
    localparam logic [SAMPLE_W-1:0] HYST_S    = SAMPLE_W'(HYST);
    localparam logic [SAMPLE_W:0]   HYST_E    = (SAMPLE_W+1)'(HYST);
    localparam logic [16:0]         CMAX      = 17'(CARRIER_MAX);
    localparam logic                LOW_BIT   = (INVERT != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_ACC,
        S_SLICE
    } state_e;

    state_e state_q, state_d;

    logic                sync_q;
    logic [SAMPLE_W-1:0] s_q, s_d;
    logic [TW-1:0]       total_q, total_d;
    logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [AVG_LOG2:0]   fill_q, fill_d;
    logic [SAMPLE_W-1:0] avg_q, avg_d;
    logic                warm_q, warm_d;
    logic                bit_q, bit_d;
    logic                edge_q, edge_d;
    logic [15:0]         period_q, period_d;
    logic                pv_q, pv_d;
    logic                carrier_q, carrier_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                have_q, have_d;
    logic                overrun_q, overrun_d;

    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic [SAMPLE_W-1:0] old_q;
    logic                ram_we;

    logic                accept;
    logic [SAMPLE_W-1:0] old_eff;
    logic [SAMPLE_W-1:0] lo;
    logic [SAMPLE_W-1:0] hi;
    logic [SAMPLE_W:0]   hi_sum;
    logic [16:0]         cnt1;
    logic [15:0]         cnt_sat;
    logic                new_bit;

    assign accept  = sync_q ^ sample_sync;
    assign old_eff = warm_q ? old_q : '0;
    assign hi_sum  = {1'b0, avg_q} + HYST_E;
    assign hi      = hi_sum[SAMPLE_W] ? '1 : hi_sum[SAMPLE_W-1:0];
    assign lo      = (avg_q >= HYST_S) ? (avg_q - HYST_S) : '0;
    assign cnt1    = {1'b0, cnt_q} + 17'd1;
    assign cnt_sat = cnt1[16] ? 16'hFFFF : cnt1[15:0];

    // Next-state for the accept/read/accumulate/slice pipeline
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        total_d   = total_q;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        avg_d     = avg_q;
        warm_d    = warm_q;
        bit_d     = bit_q;
        edge_d    = 1'b0;
        period_d  = period_q;
        pv_d      = 1'b0;
        carrier_d = carrier_q;
        cnt_d     = cnt_q;
        have_d    = have_q;
        overrun_d = overrun_q;
        ram_we    = 1'b0;
        new_bit   = bit_q;

        if (accept && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    s_d     = sample;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_ACC;
            end
            S_ACC: begin
                total_d  = total_q + TW'(s_q) - TW'(old_eff);
                avg_d    = total_d[TW-1:AVG_LOG2];
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + AVG_LOG2'(1);
                if (!warm_q) begin
                    fill_d = fill_q + (AVG_LOG2+1)'(1);
                    if (fill_d == FILL_FULL) begin
                        warm_d = 1'b1;
                    end
                end
                state_d = S_SLICE;
            end
            S_SLICE: begin
                state_d = S_IDLE;
                if (warm_q) begin
                    if (s_q < lo) begin
                        new_bit = LOW_BIT;
                    end else if (s_q > hi) begin
                        new_bit = ~LOW_BIT;
                    end
                    bit_d = new_bit;
                    if (new_bit != bit_q) begin
                        edge_d = 1'b1;
                        if (have_q) begin
                            period_d  = cnt_sat;
                            pv_d      = 1'b1;
                            carrier_d = (cnt1 <= CMAX);
                        end
                        cnt_d  = '0;
                        have_d = 1'b1;
                    end else begin
                        cnt_d = cnt_sat;
                        if (cnt1 >= CMAX) begin
                            carrier_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset reloads the sync tap so no accept is created
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            sync_q    <= sample_sync;
            s_q       <= '0;
            total_q   <= '0;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            avg_q     <= '0;
            warm_q    <= 1'b0;
            bit_q     <= 1'b0;
            edge_q    <= 1'b0;
            period_q  <= '0;
            pv_q      <= 1'b0;
            carrier_q <= 1'b0;
            cnt_q     <= '0;
            have_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sample_sync;
            s_q       <= s_d;
            total_q   <= total_d;
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            avg_q     <= avg_d;
            warm_q    <= warm_d;
            bit_q     <= bit_d;
            edge_q    <= edge_d;
            period_q  <= period_d;
            pv_q      <= pv_d;
            carrier_q <= carrier_d;
            cnt_q     <= cnt_d;
            have_q    <= have_d;
            overrun_q <= overrun_d;
        end
    end

    // Window RAM: one write port, registered read; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[wr_ptr_q] <= s_q;
        end
        if (state_q == S_READ) begin
            old_q <= mem_q[wr_ptr_q];
        end
    end

    assign bit_out      = bit_q;
    assign bit_edge     = edge_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign carrier      = carrier_q;
    assign avg_out      = avg_q;
    assign warm         = warm_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_tape_slicer.sv
// tb_adc_tape_slicer: directed vectors; edge events checked by a monitor
// against a queue of expected edge records, status checked after samples.
module tb_adc_tape_slicer;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_sync;
    logic [11:0] sample;
    logic        bit_out;
    logic        bit_edge;
    logic [15:0] period;
    logic        period_valid;
    logic        carrier;
    logic [11:0] avg_out;
    logic        warm;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        b;
        logic        pv;
        logic [15:0] per;
        logic        car;
    } edge_t;

    edge_t exp_q[$];

    adc_tape_slicer #(
        .SAMPLE_W(12),
        .AVG_LOG2(3),
        .HYST(100),
        .INVERT(1),
        .CARRIER_MAX(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sample_sync(sample_sync),
        .sample(sample),
        .bit_out(bit_out),
        .bit_edge(bit_edge),
        .period(period),
        .period_valid(period_valid),
        .carrier(carrier),
        .avg_out(avg_out),
        .warm(warm),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: each bit_edge pulse consumes one expected edge record
    always @(negedge clk) begin
        if (bit_edge === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL edge_unexpected: got edge bit=%0d expected none",
                         bit_out);
            end else begin
                edge_t e;
                e = exp_q.pop_front();
                chk("edge_bit", bit_out, e.b);
                chk("edge_pv", period_valid, e.pv);
                chk("edge_period", period, e.per);
                chk("edge_carrier", carrier, e.car);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] v);
        sample      = v;
        sample_sync = ~sample_sync;
        tick(6);
    endtask

    task automatic expect_edge(input logic b, input logic pv,
                               input logic [15:0] per, input logic car);
        edge_t e;
        e.b   = b;
        e.pv  = pv;
        e.per = per;
        e.car = car;
        exp_q.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bit_out"}, bit_out, 0);
        chk({tag, "_bit_edge"}, bit_edge, 0);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_period_valid"}, period_valid, 0);
        chk({tag, "_carrier"}, carrier, 0);
        chk({tag, "_avg_out"}, avg_out, 0);
        chk({tag, "_warm"}, warm, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        reset       = 1'b0;
        sample_sync = 1'b0;
        sample      = '0;
        tick(3);
        chk_all_zero("reset");
        reset = 1'b1;
        tick(2);
        chk("post_reset_overrun", overrun, 0);

        // Warm-up: 8 x 2000
        for (int i = 0; i < 7; i++) send(12'd2000);
        chk("warm_after7", warm, 0);
        send(12'd2000);
        chk("warm_after8", warm, 1);
        chk("avg_after8", avg_out, 2000);
        chk("bit_after8", bit_out, 0);

        // Hysteresis hold
        send(12'd1950);
        chk("hyst_avg1", avg_out, 1993);
        chk("hyst_bit1", bit_out, 0);
        send(12'd2080);
        chk("hyst_avg2", avg_out, 2003);
        chk("hyst_bit2", bit_out, 0);
        for (int i = 0; i < 8; i++) send(12'd2000);
        chk("restore_avg", avg_out, 2000);

        // Square wave 4 high / 4 low
        for (int blk = 0; blk < 5; blk++) begin
            case (blk)
                1: expect_edge(1'b1, 1'b0, 16'd0, 1'b0);
                2: expect_edge(1'b0, 1'b1, 16'd4, 1'b1);
                3: expect_edge(1'b1, 1'b1, 16'd4, 1'b1);
                4: expect_edge(1'b0, 1'b1, 16'd4, 1'b1);
                default: ;
            endcase
            for (int i = 0; i < 4; i++) begin
                send((blk % 2 == 0) ? 12'd2400 : 12'd1600);
            end
            chk("sq_bit", bit_out, (blk % 2 == 0) ? 0 : 1);
        end
        chk("sq_carrier", carrier, 1);
        chk("sq_avg", avg_out, 2000);

        // Carrier loss: steady level, drops on 20th sample since edge
        for (int i = 0; i < 16; i++) send(12'd2400);
        chk("carrier_s19", carrier, 1);
        send(12'd2400);
        chk("carrier_s20", carrier, 0);
        chk("loss_avg", avg_out, 2400);
        expect_edge(1'b1, 1'b1, 16'd21, 1'b0);
        send(12'd1600);
        chk("loss_bit", bit_out, 1);
        chk("loss_carrier", carrier, 0);

        // Low saturation
        for (int i = 0; i < 8; i++) send(12'd50);
        chk("sat_lo_avg", avg_out, 50);
        expect_edge(1'b0, 1'b1, 16'd9, 1'b1);
        send(12'd200);
        chk("sat_lo_avg2", avg_out, 68);
        send(12'd0);
        chk("sat_lo_avg3", avg_out, 62);
        chk("sat_lo_bit", bit_out, 0);

        // High saturation
        for (int i = 0; i < 8; i++) send(12'd4050);
        chk("sat_hi_avg", avg_out, 4050);
        chk("sat_hi_bit0", bit_out, 0);
        expect_edge(1'b1, 1'b1, 16'd10, 1'b1);
        send(12'd3800);
        chk("sat_hi_avg2", avg_out, 4018);
        send(12'd4095);
        chk("sat_hi_avg3", avg_out, 4024);
        chk("sat_hi_bit", bit_out, 1);

        // Overrun: second toggle one cycle later is dropped
        sample      = 12'd4095;
        sample_sync = ~sample_sync;
        tick(1);
        sample      = 12'd0;
        sample_sync = ~sample_sync;
        tick(6);
        chk("ovr_flag", overrun, 1);
        chk("ovr_avg", avg_out, 4030);
        chk("ovr_bit", bit_out, 1);

        // Reset while the pipeline sits in ACC
        sample      = 12'd1000;
        sample_sync = ~sample_sync;
        tick(2);
        reset = 1'b0;
        tick(1);
        chk_all_zero("midreset");
        reset = 1'b1;
        tick(2);
        for (int i = 0; i < 7; i++) send(12'd1000);
        chk("rewarm_after7", warm, 0);
        send(12'd1000);
        chk("rewarm_after8", warm, 1);
        chk("rewarm_avg", avg_out, 1000);
        chk("rewarm_bit", bit_out, 0);
        chk("rewarm_overrun", overrun, 0);

        tick(5);
        chk("edges_pending", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
